// File: rtl/requant_relu_pkg.sv
// Shared types and constants for the requant_relu post-convolution stage.
// Also provides the SRAM write-request encodings used across the
// accelerator, unless another file has already defined them.

`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

package requant_relu_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_PARAM = 3'd1,
        LD_BIAS  = 3'd2,
        RD       = 3'd3,
        CALC     = 3'd4,
        WR       = 3'd5,
        FINISH   = 3'd6
    } state_e;

    // Word offsets inside the layer parameter SRAM
    localparam logic [1:0] PARAM_ROW   = 2'd0;
    localparam logic [1:0] PARAM_CH    = 2'd1;
    localparam logic [1:0] PARAM_SHIFT = 2'd2;
    localparam logic [1:0] PARAM_RELU  = 2'd3;

    // int8 saturation limits as raw bytes
    localparam logic [7:0] INT8_MAX = 8'h7F;
    localparam logic [7:0] INT8_MIN = 8'h80;

    // SRAM port geometry
    localparam int SRAM_AW = 32;
    localparam int SRAM_DW = 32;

endpackage

// File: rtl/sp_ram_intf.sv
// Single-port SRAM interface. The compute side drives the request and
// receives read data one cycle after cs/addr are presented.

interface sp_ram_intf;
    import requant_relu_pkg::*;

    logic               cs;
    logic               oe;
    logic               W_req;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] W_data;
    logic [SRAM_DW-1:0] R_data;

    modport compute (
        output cs,
        output oe,
        output W_req,
        output addr,
        output W_data,
        input  R_data
    );

    modport memory (
        input  cs,
        input  oe,
        input  W_req,
        input  addr,
        input  W_data,
        output R_data
    );

endinterface

// File: rtl/requant_relu_sat.sv
// requant_sat: combinational requantiser. Adds bias to a partial sum,
// arithmetic-shifts right, saturates to int8 and optionally applies ReLU.
// Build option: define REQUANT_ROUND_EN to round half up before the shift;
// otherwise the shift truncates toward -inf and no rounding adder exists.

module requant_sat
    import requant_relu_pkg::*;
(
    input  logic signed [31:0] psum,
    input  logic signed [31:0] bias,
    input  logic        [4:0]  shift,
    input  logic               relu,
    output logic        [7:0]  q_byte
);

    // Two guard bits: one for the psum+bias carry, one for the rounding term.
    localparam int SUM_W = 34;
    localparam logic signed [SUM_W-1:0] SAT_HI = 34'sd127;
    localparam logic signed [SUM_W-1:0] SAT_LO = -34'sd128;

    function automatic logic [7:0] sat_int8(input logic signed [SUM_W-1:0] v);
        logic [7:0] r;
        if (v > SAT_HI) begin
            r = INT8_MAX;
        end else if (v < SAT_LO) begin
            r = INT8_MIN;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [7:0] relu_clip(input logic [7:0] b, input logic en);
        return (en && b[7]) ? 8'h00 : b;
    endfunction

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_r;
    logic signed [SUM_W-1:0] q;

`ifdef REQUANT_ROUND_EN
    localparam logic signed [SUM_W-1:0] ONE = 34'sd1;
    logic signed [SUM_W-1:0] rnd;
`endif

    // Bias add, optional rounding, shift, saturate and ReLU
    always_comb begin
        sum = $signed({{2{psum[31]}}, psum}) + $signed({{2{bias[31]}}, bias});
`ifdef REQUANT_ROUND_EN
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = ONE <<< (shift - 5'd1);
        end
        sum_r = sum + rnd;
`else
        sum_r = sum;
`endif
        q      = sum_r >>> shift;
        q_byte = relu_clip(sat_int8(q), relu);
    end

endmodule

// File: rtl/requant_relu.sv
// requant_relu: post-convolution requantisation stage. Loads layer
// parameters, then for each channel loads its bias and walks every pixel:
// read psum, requantise to int8, write the byte to the feature-map SRAM.
// Output layout is channel-major then row-major, matching max pooling.
// Build option: REQUANT_ROUND_EN enables round-half-up in requant_sat.

module requant_relu
    import requant_relu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 18
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        finish,
    sp_ram_intf.compute param_intf,
    sp_ram_intf.compute bias_intf,
    sp_ram_intf.compute input_intf,
    sp_ram_intf.compute output_intf,
    sp_ram_intf.compute weight_intf
);

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [CNT_W-1:0]   pix_q, pix_d;
    logic [7:0]         ch_q, ch_d;
    logic [ADDR_W-1:0]  elem_addr_q, elem_addr_d;
    logic [5:0]         num_row_q, num_row_d;
    logic [7:0]         num_ch_q, num_ch_d;
    logic [4:0]         shift_q, shift_d;
    logic               relu_q, relu_d;
    logic signed [31:0] bias_q, bias_d;
    logic [7:0]         byte_q, byte_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic               out_wreq_q, out_wreq_d;

    logic [CNT_W-1:0]   npix;
    logic               last_pix;
    logic               last_ch;
    logic [7:0]         calc_byte;
    logic               unused_rdata;

    assign npix     = CNT_W'(num_row_q) * CNT_W'(num_row_q);
    assign last_pix = (pix_q == npix - CNT_W'(1));
    assign last_ch  = (ch_q == num_ch_q - 8'd1);

    requant_sat u_requant_sat (
        .psum   ($signed(input_intf.R_data)),
        .bias   (bias_q),
        .shift  (shift_q),
        .relu   (relu_q),
        .q_byte (calc_byte)
    );

    // Next-state, counters and captured values for the sequencing FSM
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        pix_d       = pix_q;
        ch_d        = ch_q;
        elem_addr_d = elem_addr_q;
        num_row_d   = num_row_q;
        num_ch_d    = num_ch_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        bias_d      = bias_q;
        byte_d      = byte_q;
        out_addr_d  = out_addr_q;
        out_wreq_d  = out_wreq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_PARAM;
                    step_d  = 3'd0;
                end
            end
            LD_PARAM: begin
                // Address k goes out at step k; its data arrives at step k+1.
                step_d = step_q + 3'd1;
                if (step_q == 3'(PARAM_ROW) + 3'd1) begin
                    num_row_d = param_intf.R_data[5:0];
                end
                if (step_q == 3'(PARAM_CH) + 3'd1) begin
                    num_ch_d = param_intf.R_data[7:0];
                end
                if (step_q == 3'(PARAM_SHIFT) + 3'd1) begin
                    shift_d = param_intf.R_data[4:0];
                end
                if (step_q == 3'(PARAM_RELU) + 3'd1) begin
                    relu_d = param_intf.R_data[0];
                    step_d = 3'd0;
                    if ((num_row_q == 6'd0) || (num_ch_q == 8'd0)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = LD_BIAS;
                    end
                end
            end
            LD_BIAS: begin
                if (step_q == 3'd0) begin
                    step_d = 3'd1;
                end else begin
                    bias_d  = $signed(bias_intf.R_data);
                    step_d  = 3'd0;
                    state_d = RD;
                end
            end
            RD: begin
                state_d = CALC;
            end
            CALC: begin
                byte_d     = calc_byte;
                out_addr_d = elem_addr_q;
                out_wreq_d = `WRITE_ENB;
                state_d    = WR;
            end
            WR: begin
                out_wreq_d  = `WRITE_DIS;
                elem_addr_d = elem_addr_q + ADDR_W'(1);
                if (last_pix) begin
                    pix_d = '0;
                    if (last_ch) begin
                        state_d = FINISH;
                    end else begin
                        ch_d    = ch_q + 8'd1;
                        state_d = LD_BIAS;
                    end
                end else begin
                    pix_d   = pix_q + CNT_W'(1);
                    state_d = RD;
                end
            end
            FINISH: begin
                // A low phase on start is required before another run.
                if (!start) begin
                    state_d     = IDLE;
                    elem_addr_d = '0;
                    ch_d        = '0;
                    pix_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            step_q      <= '0;
            pix_q       <= '0;
            ch_q        <= '0;
            elem_addr_q <= '0;
            num_row_q   <= '0;
            num_ch_q    <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            byte_q      <= '0;
            out_addr_q  <= '0;
            out_wreq_q  <= `WRITE_DIS;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pix_q       <= pix_d;
            ch_q        <= ch_d;
            elem_addr_q <= elem_addr_d;
            num_row_q   <= num_row_d;
            num_ch_q    <= num_ch_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            bias_q      <= bias_d;
            byte_q      <= byte_d;
            out_addr_q  <= out_addr_d;
            out_wreq_q  <= out_wreq_d;
        end
    end

    assign finish = (state_q == FINISH);

    // Parameter SRAM: four words read back to back, addresses held at 0 otherwise
    assign param_intf.cs     = (state_q == LD_PARAM) && (step_q < 3'd4);
    assign param_intf.addr   = param_intf.cs ? SRAM_AW'(step_q) : '0;
    assign param_intf.oe     = 1'b1;
    assign param_intf.W_req  = `WRITE_DIS;
    assign param_intf.W_data = '0;

    // Bias SRAM: a single read per channel on the first LD_BIAS cycle
    assign bias_intf.cs      = (state_q == LD_BIAS) && (step_q == 3'd0);
    assign bias_intf.addr    = (state_q == LD_BIAS) ? SRAM_AW'(ch_q) : '0;
    assign bias_intf.oe      = 1'b1;
    assign bias_intf.W_req   = `WRITE_DIS;
    assign bias_intf.W_data  = '0;

    // Psum SRAM: one read per element
    assign input_intf.cs     = (state_q == RD);
    assign input_intf.addr   = (state_q == RD) ? SRAM_AW'(elem_addr_q) : '0;
    assign input_intf.oe     = 1'b1;
    assign input_intf.W_req  = `WRITE_DIS;
    assign input_intf.W_data = '0;

    // Feature-map SRAM: address and request registered in CALC, strobed in WR
    assign output_intf.cs     = (state_q == WR);
    assign output_intf.addr   = SRAM_AW'(out_addr_q);
    assign output_intf.oe     = 1'b1;
    assign output_intf.W_req  = out_wreq_q;
    assign output_intf.W_data = {24'h0, byte_q};

    // Weight SRAM is not used by this stage
    assign weight_intf.cs     = 1'b0;
    assign weight_intf.addr   = '0;
    assign weight_intf.oe     = 1'b1;
    assign weight_intf.W_req  = `WRITE_DIS;
    assign weight_intf.W_data = '0;

    assign unused_rdata = ^{weight_intf.R_data, output_intf.R_data, param_intf.R_data[31:8]};

endmodule
